// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM encoding and line levels.
package fifo_uart_pkg;

    localparam int STATE_W = 3;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/baud_cnt.sv
// Modulo-CLK_DIV bit-period counter; tick marks the last cycle of each bit period.
module baud_cnt #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each as an async serial frame,
// streaming frames back to back while the FIFO stays non-empty.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_val,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read,
    output logic              tx,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    uart_state_e       state;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              parity_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick;
    logic              baud_clr;
    logic              last_stop;

    // The baud counter idles at zero so the start bit gets a full period; every other
    // state change happens on a tick, where the counter wraps to zero by itself.
    assign baud_clr  = (state == ST_IDLE);
    assign last_stop = (state == ST_STOP) && tick && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign fifo_read = reset && en && fifo_val && ((state == ST_IDLE) || last_stop);
    assign busy      = (state != ST_IDLE) || fifo_read;
    assign shift_nxt = shift_q >> 1;

    baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_cnt  <= '0;
            tx       <= LINE_IDLE;
        end else if (fifo_read) begin
            state    <= ST_START;
            shift_q  <= fifo_data;
            parity_q <= ^fifo_data;
            bit_cnt  <= '0;
            tx       <= ~LINE_IDLE;
        end else begin
            case (state)
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_nxt;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                tx    <= parity_q;
                            end else begin
                                state <= ST_STOP;
                                tx    <= LINE_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_nxt[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= LINE_IDLE;
                    end
                end
                ST_STOP: begin
                    if (last_stop) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        tx      <= LINE_IDLE;
                    end else if (tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    tx      <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage directly downstream of the byte FIFOs (`ring_fifo` / `fifo_sh`). It pops words through the FIFO's `read`/`dataout`/`val` interface and shifts each word out as an asynchronous serial frame on a single line: start bit, data LSB first, optional even parity, stop bit(s). Frames stream back to back with no idle gap while the FIFO stays non-empty.

## Interface
- `DATA_W`, 8: data bits per frame; must equal the FIFO `DATA_W`.
- `CLK_DIV`, 16: clock cycles per serial bit, ≥ 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 allows new frames to start; 0 lets the current frame finish, then holds idle.
- `fifo_val`  in  1  FIFO `val`: `fifo_data` holds a valid head word.
- `fifo_data`  in  DATA_W  FIFO `dataout`, first-word-fall-through.
- `fifo_read`  out  1  one-cycle pop strobe to FIFO `read`.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the pop cycle through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (only if `PARITY_EN`), STOP.
- IDLE: `tx`=1. If `en` & `fifo_val`, assert `fifo_read` for one cycle, latch `fifo_data` into the shift register in the same cycle, compute parity = ^`fifo_data`, go to START.
- START: `tx`=0 for `CLK_DIV` cycles.
- DATA: `tx` = shift register bit 0; shift right every `CLK_DIV` cycles; `DATA_W` bits total.
- PARITY: `tx` = latched even-parity bit for `CLK_DIV` cycles.
- STOP: `tx`=1 for `STOP_BITS`*`CLK_DIV` cycles. In the final STOP cycle, if `en` & `fifo_val`, pop and latch as in IDLE and go directly to START; otherwise go to IDLE.
- `fifo_read` is never asserted when `fifo_val`=0; at most one pop per frame.
- Counters: baud counter `$clog2(CLK_DIV)` bits, counts 0..`CLK_DIV`-1 and wraps; bit counter `$clog2(DATA_W+1)` bits. Both clear on every state change.
- `en` falling mid-frame has no effect on that frame.

## Timing
- Reset (async assert, sync release): state IDLE, `tx`=1, `fifo_read`=0, `busy`=0, counters 0, shift register 0.
- Reset mid-frame: `tx` returns to 1 immediately; a popped, untransmitted word is discarded.
- Pop at cycle t: start bit occupies cycles t+1..t+`CLK_DIV`; data bit i occupies t+1+(i+1)·`CLK_DIV` .. t+(i+2)·`CLK_DIV`.
- Frame length F = (1+`DATA_W`+`PARITY_EN`+`STOP_BITS`)·`CLK_DIV` cycles.
- Streaming: consecutive pops exactly F cycles apart; no idle cycle between frames.
- From IDLE: one cycle of latency (the pop cycle, `tx`=1) before the start bit.
- `busy` = 1 in the pop cycle and in every START/DATA/PARITY/STOP cycle.

## Structure
- Shared package `fifo_uart_pkg`: state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3-bit state width, line idle level.
- One sub-module: `baud_cnt`, a parameterised modulo-`CLK_DIV` counter with synchronous clear and a `tick` output on the last count. The FSM, shift register and parity logic stay in the top module.

## Test plan
- Reset: hold `reset`=0 with `fifo_val`=1 → `tx`=1, `fifo_read`=0, `busy`=0 throughout; assert `reset` mid-frame → `tx`=1 in the same cycle.
- Single byte: `CLK_DIV`=4, `PARITY_EN`=0, push 0xA5 → one `fifo_read` pulse; `tx` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; `busy` high for 41 cycles.
- Parity: `PARITY_EN`=1, bytes 0xA5 and 0x01 → parity bit 0 then 1; pops 44 cycles apart.
- Streaming: 10 bytes preloaded into `ring_fifo` (depth 10), `en`=1 → 10 pops exactly F=40 cycles apart (`CLK_DIV`=4), no `tx`=1 gap between a stop bit and the next start bit; the FIFO drains to `val`=0 and `tx` then idles at 1.
- Enable: drop `en` in the middle of frame 2 of 5 → frame 2 completes intact, no further pop; raise `en` → next pop one cycle later, start bit on the following cycle.
- Empty FIFO: `fifo_val`=0 for 100 cycles with `en`=1 → no `fifo_read`, `tx`=1, `busy`=0; the random write/read mix from the FIFO bench drives the received byte stream, which must equal the written order.
